// File: rtl/costas_pkg.sv
// rtl/costas_pkg.sv - shared types, widths and saturation helper for the Costas loop filter
//
// Contents:
//   ACC_W              default integrator / correction width
//   FCW_CENTER         default nominal carrier frequency word (fc/fs * 2^32)
//   lock_state_t       carrier lock FSM states
//   sat_clamp()        clamps a signed ACC_W+1 bit sum to +/-lim, returning ACC_W bits

package costas_pkg;

  localparam int ACC_W = 32;
  localparam logic [ACC_W-1:0] FCW_CENTER = 32'h4000_0000;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // The sum carries one guard bit, so comparing against the limit is exact
  // even when both addends sit at the extremes of ACC_W.
  function automatic logic signed [ACC_W-1:0] sat_clamp(
    input logic signed [ACC_W:0]   x,
    input logic        [ACC_W-1:0] lim
  );
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    hi = $signed({1'b0, lim});
    lo = -hi;
    if (x > hi) begin
      sat_clamp = hi[ACC_W-1:0];
    end else if (x < lo) begin
      sat_clamp = lo[ACC_W-1:0];
    end else begin
      sat_clamp = x[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/costas_loop_filter_if.sv
// rtl/costas_loop_filter_if.sv - phase-error in / frequency-word out bundle of the Costas loop filter
//
// Signals:
//   err_valid    phase detector strobe, phase_error valid this cycle
//   phase_error  signed 16-bit phase error
//   loop_clr     synchronous clear of the integrator and pipeline
//   freq_word    NCO frequency control word
//   fcw_valid    one-cycle strobe, freq_word updated this cycle
//   locked       carrier lock indicator
// Modports:
//   master  phase detector / control side (drives err_valid, phase_error, loop_clr)
//   slave   loop filter side (drives freq_word, fcw_valid, locked)

interface costas_loop_filter_if #(
  parameter int ACC_W = costas_pkg::ACC_W
);

  logic               err_valid;
  logic signed [15:0] phase_error;
  logic               loop_clr;
  logic [ACC_W-1:0]   freq_word;
  logic               fcw_valid;
  logic               locked;

  modport master (
    output err_valid,
    output phase_error,
    output loop_clr,
    input  freq_word,
    input  fcw_valid,
    input  locked
  );

  modport slave (
    input  err_valid,
    input  phase_error,
    input  loop_clr,
    output freq_word,
    output fcw_valid,
    output locked
  );

endinterface

// File: rtl/costas_lock_detect.sv
// rtl/costas_lock_detect.sv - carrier lock detector, two-state FSM with consecutive-sample counter
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   err_valid    phase error strobe; the FSM only advances on strobes
//   phase_error  signed 16-bit phase error
//   clr          synchronous clear: counter to 0, FSM to UNLOCKED
//   locked       1 while the FSM is in LOCKED
//
// In UNLOCKED the counter tracks consecutive in-band samples (|err| < LOCK_THRESH);
// in LOCKED it tracks consecutive out-of-band samples. LOCK_CNT of them flips the state.

module costas_lock_detect
  import costas_pkg::*;
#(
  parameter logic [15:0] LOCK_THRESH = 16'd2048,
  parameter int          LOCK_CNT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               err_valid,
  input  logic signed [15:0] phase_error,
  input  logic               clr,
  output logic               locked
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);

  lock_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [15:0]      mag;
  logic             in_band;
  logic             qualify;

  // |-32768| does not fit in 16 bits; it is folded onto the largest positive value.
  always_comb begin
    mag = phase_error;
    if (phase_error == 16'sh8000) begin
      mag = 16'h7FFF;
    end else if (phase_error[15]) begin
      mag = 16'(-phase_error);
    end
    in_band = (mag < LOCK_THRESH);
    qualify = (state == UNLOCKED) ? in_band : !in_band;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNLOCKED;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The count tops out at LOCK_CNT-1 and the next qualifying sample flips the
  // state instead of incrementing, so the counter can never wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (clr) begin
      state_next = UNLOCKED;
      cnt_next   = '0;
    end else if (err_valid) begin
      if (qualify) begin
        if (cnt >= CNT_LAST) begin
          state_next = (state == UNLOCKED) ? LOCKED : UNLOCKED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else begin
        cnt_next = '0;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/costas_loop_filter.sv
// rtl/costas_loop_filter.sv - PI loop filter turning Costas phase error into an NCO frequency word
//
// Ports:
//   sys_clk   system clock
//   sys_rst   asynchronous active-high reset
//   bus       costas_loop_filter_if.slave:
//               err_valid / phase_error / loop_clr in, freq_word / fcw_valid / locked out
//
// Pipeline: stage 1 registers the proportional term and updates the saturating
// integrator; stage 2 adds them, clamps the correction and offsets it from
// FCW_CENTER. err_valid in cycle n gives fcw_valid in cycle n+2, one result per cycle.
//
// Optional feature: define COSTAS_LOCK_DETECT_EN to build the lock detector;
// otherwise locked is tied to 0.

module costas_loop_filter #(
  parameter int                 KP_SHIFT    = 12,
  parameter int                 KI_SHIFT    = 4,
  parameter int                 ACC_W       = costas_pkg::ACC_W,
  parameter logic [ACC_W-1:0]   INT_LIMIT   = 32'h0100_0000,
  parameter logic [ACC_W-1:0]   CORR_LIMIT  = 32'h0200_0000,
  parameter logic [ACC_W-1:0]   FCW_CENTER  = costas_pkg::FCW_CENTER,
  parameter logic [15:0]        LOCK_THRESH = 16'd2048,
  parameter int                 LOCK_CNT    = 64
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  costas_loop_filter_if.slave  bus
);

  logic signed [ACC_W-1:0] err_ext;
  logic signed [ACC_W-1:0] p_term;
  logic signed [ACC_W-1:0] i_term;
  logic signed [ACC_W:0]   integ_sum;
  logic signed [ACC_W-1:0] integ_next;
  logic signed [ACC_W:0]   corr_sum;
  logic signed [ACC_W-1:0] corr;

  logic signed [ACC_W-1:0] p_reg;
  logic signed [ACC_W-1:0] integ;
  logic                    v1;
  logic [ACC_W-1:0]        freq_word_q;
  logic                    fcw_valid_q;

  // Both gains are shifts of the sign-extended error; with ACC_W=32 the largest
  // proportional term (2^15 << 12) still fits, so only the sums need a guard bit.
  always_comb begin
    err_ext    = {{(ACC_W-16){bus.phase_error[15]}}, bus.phase_error};
    p_term     = err_ext <<< KP_SHIFT;
    i_term     = err_ext <<< KI_SHIFT;
    integ_sum  = {integ[ACC_W-1], integ} + {i_term[ACC_W-1], i_term};
    integ_next = costas_pkg::sat_clamp(integ_sum, INT_LIMIT);
    // Stage 2 reads the integrator register, which already holds the value
    // updated by the same sample whose proportional term sits in p_reg.
    corr_sum   = {p_reg[ACC_W-1], p_reg} + {integ[ACC_W-1], integ};
    corr       = costas_pkg::sat_clamp(corr_sum, CORR_LIMIT);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p_reg       <= '0;
      integ       <= '0;
      v1          <= 1'b0;
      freq_word_q <= FCW_CENTER;
      fcw_valid_q <= 1'b0;
    end else if (bus.loop_clr) begin
      // Re-acquisition: drop any in-flight or coincident sample and hand the
      // NCO its nominal word straight away.
      p_reg       <= '0;
      integ       <= '0;
      v1          <= 1'b0;
      freq_word_q <= FCW_CENTER;
      fcw_valid_q <= 1'b1;
    end else begin
      v1          <= bus.err_valid;
      fcw_valid_q <= v1;
      if (bus.err_valid) begin
        p_reg <= p_term;
        integ <= integ_next;
      end
      // Modulo-2^ACC_W add: the NCO phase accumulator wraps the same way.
      if (v1) begin
        freq_word_q <= FCW_CENTER + $unsigned(corr);
      end
    end
  end

  assign bus.freq_word = freq_word_q;
  assign bus.fcw_valid = fcw_valid_q;

`ifdef COSTAS_LOCK_DETECT_EN
  logic lock_q;

  costas_lock_detect #(
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_CNT    (LOCK_CNT)
  ) u_lock_detect (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .err_valid   (bus.err_valid),
    .phase_error (bus.phase_error),
    .clr         (bus.loop_clr),
    .locked      (lock_q)
  );

  assign bus.locked = lock_q;
`else
  // Lock configuration is kept on the parameter list so both builds share one
  // instantiation template; without the detector it has no effect.
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_THRESH, LOCK_CNT[0]};
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_costas_loop_filter.sv
// tb/tb_costas_loop_filter.sv - self-checking bench for costas_loop_filter

module tb_costas_loop_filter;

  localparam longint CENTER = 64'h4000_0000;
  localparam longint I_LIM  = 64'h0100_0000;
  localparam longint C_LIM  = 64'h0200_0000;

  logic sys_clk;
  logic sys_rst;

  costas_loop_filter_if bus ();

  costas_loop_filter dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  longint      m_integ;
  bit          m_pend_v;
  logic [31:0] m_pend_w;
  bit          m_valid;
  logic [31:0] m_word;
  bit          m_locked;
  int          m_cnt;

  function automatic longint lclamp(input longint x, input longint lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    longint e;
    longint mag;
    bit     in_band;
    bit     qual;
    if (sys_rst) begin
      m_integ  = 0;
      m_pend_v = 0;
      m_pend_w = 32'(CENTER);
      m_valid  = 0;
      m_word   = 32'(CENTER);
      m_locked = 0;
      m_cnt    = 0;
    end else if (bus.loop_clr) begin
      m_integ  = 0;
      m_pend_v = 0;
      m_valid  = 1;
      m_word   = 32'(CENTER);
      m_locked = 0;
      m_cnt    = 0;
    end else begin
      m_valid = m_pend_v;
      if (m_pend_v) m_word = m_pend_w;
      m_pend_v = 0;
      if (bus.err_valid) begin
        e        = bus.phase_error;
        m_integ  = lclamp(m_integ + e * 16, I_LIM);
        m_pend_w = 32'(CENTER + lclamp(e * 4096 + m_integ, C_LIM));
        m_pend_v = 1;
`ifdef COSTAS_LOCK_DETECT_EN
        mag     = (e < 0) ? -e : e;
        if (mag > 32767) mag = 32767;
        in_band = (mag < 2048);
        qual    = m_locked ? !in_band : in_band;
        if (qual) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == 64) begin
            m_locked = !m_locked;
            m_cnt    = 0;
          end
        end else begin
          m_cnt = 0;
        end
`else
        mag     = 0;
        in_band = 0;
        qual    = 0;
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    n_assert++;
    if (bus.fcw_valid !== m_valid) begin
      n_fail++;
      $display("FAIL cyc_fcw_valid t=%0t got %b want %b", $time, bus.fcw_valid, m_valid);
    end
    n_assert++;
    if (bus.freq_word !== m_word) begin
      n_fail++;
      $display("FAIL cyc_freq_word t=%0t got %h want %h", $time, bus.freq_word, m_word);
    end
    n_assert++;
    if (bus.locked !== m_locked) begin
      n_fail++;
      $display("FAIL cyc_locked t=%0t got %b want %b", $time, bus.locked, m_locked);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
    end
  endtask

  task automatic step(input logic ev, input logic [15:0] pe, input logic clr);
    @(negedge sys_clk);
    bus.err_valid   = ev;
    bus.phase_error = pe;
    bus.loop_clr    = clr;
  endtask

  initial begin
    sys_rst         = 1'b1;
    bus.err_valid   = 1'b0;
    bus.phase_error = '0;
    bus.loop_clr    = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    // idle after reset
    repeat (100) step(0, 16'h0000, 0);
    chk("rst_freq_word", bus.freq_word, 32'h4000_0000);
    chk("rst_fcw_valid", {31'b0, bus.fcw_valid}, 32'd0);
    chk("rst_locked", {31'b0, bus.locked}, 32'd0);

    // single strobe, latency 2
    step(1, 16'd1, 0);
    step(0, 16'h0000, 0);
    chk("lat_n1_valid", {31'b0, bus.fcw_valid}, 32'd0);
    step(0, 16'h0000, 0);
    chk("lat_n2_valid", {31'b0, bus.fcw_valid}, 32'd1);
    chk("single_word", bus.freq_word, 32'h4000_1010);
    step(0, 16'h0000, 0);
    chk("single_hold_valid", {31'b0, bus.fcw_valid}, 32'd0);
    chk("single_hold_word", bus.freq_word, 32'h4000_1010);

    // saturate positive
    repeat (2000) step(1, 16'h7FFF, 0);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("sat_pos_word", bus.freq_word, 32'h4200_0000);
    step(1, 16'h0000, 0);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("integ_pinned_pos", bus.freq_word, 32'h4100_0000);

    // most negative error pulls the integrator down without wrapping
    repeat (10) step(1, 16'h8000, 0);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("neg_corr_word", bus.freq_word, 32'h3E00_0000);
    step(1, 16'h0000, 0);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("integ_recover", bus.freq_word, 32'h40B0_0000);
    repeat (100) step(1, 16'h8000, 0);
    step(1, 16'h0000, 0);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("integ_pinned_neg", bus.freq_word, 32'h3F00_0000);

    // saturate again, then loop_clr coinciding with a strobe
    repeat (70) step(1, 16'h7FFF, 0);
    step(1, 16'h7FFF, 1);
    step(1, 16'h0000, 0);
    chk("clr_valid", {31'b0, bus.fcw_valid}, 32'd1);
    chk("clr_word", bus.freq_word, 32'h4000_0000);
    step(0, 16'h0000, 0);
    chk("clr_gap_valid", {31'b0, bus.fcw_valid}, 32'd0);
    step(0, 16'h0000, 0);
    chk("after_clr_valid", {31'b0, bus.fcw_valid}, 32'd1);
    chk("after_clr_word", bus.freq_word, 32'h4000_0000);

    // asynchronous reset with a sample in flight
    step(1, 16'h0100, 0);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk("pre_rst_word", bus.freq_word, 32'h4010_1000);
    step(1, 16'h0005, 0);
    @(posedge sys_clk);
    #1;
    bus.err_valid = 1'b0;
    sys_rst       = 1'b1;
    #1;
    chk("async_rst_word", bus.freq_word, 32'h4000_0000);
    chk("async_rst_valid", {31'b0, bus.fcw_valid}, 32'd0);
    chk("async_rst_locked", {31'b0, bus.locked}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(0, 16'h0000, 0);
      chk("post_rst_no_valid", {31'b0, bus.fcw_valid}, 32'd0);
    end

`ifdef COSTAS_LOCK_DETECT_EN
    step(0, 16'h0000, 1);
    repeat (63) step(1, 16'd100, 0);
    step(0, 16'h0000, 0);
    chk("lock_63", {31'b0, bus.locked}, 32'd0);
    step(1, 16'd100, 0);
    step(0, 16'h0000, 0);
    chk("lock_64", {31'b0, bus.locked}, 32'd1);
    step(1, 16'd3000, 0);
    repeat (10) step(1, 16'd100, 0);
    step(0, 16'h0000, 0);
    chk("lock_glitch", {31'b0, bus.locked}, 32'd1);
    repeat (63) step(1, 16'd3000, 0);
    step(0, 16'h0000, 0);
    chk("unlock_63", {31'b0, bus.locked}, 32'd1);
    step(1, 16'd3000, 0);
    step(0, 16'h0000, 0);
    chk("unlock_64", {31'b0, bus.locked}, 32'd0);
`else
    repeat (70) step(1, 16'd100, 0);
    step(0, 16'h0000, 0);
    chk("lock_disabled", {31'b0, bus.locked}, 32'd0);
`endif

    repeat (4) step(0, 16'h0000, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/costas_loop_filter.md
Name: costas_loop_filter

Overview:
- Second-order proportional-integral (PI) loop filter for the QPSK carrier-recovery (Costas) loop.
- Sits directly downstream of the phase detector. Consumes its 16-bit signed phase error at the symbol-rate strobe.
- Produces the 32-bit frequency control word that drives the local-carrier NCO, so the loop settles to zero phase error.
- Optionally reports carrier lock.

Parameters:
- KP_SHIFT, 12: proportional gain as a left shift of the sign-extended error (Kp = 2^KP_SHIFT).
- KI_SHIFT, 4: integral gain as a left shift of the sign-extended error (Ki = 2^KI_SHIFT).
- ACC_W, 32: integrator and correction width, in bits.
- INT_LIMIT, 32'h0100_0000: symmetric saturation bound of the integrator, ±INT_LIMIT.
- CORR_LIMIT, 32'h0200_0000: symmetric saturation bound of the total correction, ±CORR_LIMIT.
- FCW_CENTER, 32'h4000_0000: nominal carrier frequency word (fc/fs × 2^32).
- LOCK_THRESH, 16'd2048: |phase_error| below this value counts as "in lock".
- LOCK_CNT, 64: number of consecutive qualifying samples needed to change lock state.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst, input, 1: asynchronous active-high reset.
- err_valid, input, 1: one-cycle strobe; phase_error is valid this cycle.
- phase_error, input, 16: signed two's-complement phase error from the phase detector.
- loop_clr, input, 1: synchronous clear of the integrator and pipeline (used on re-acquisition).
- freq_word, output, 32: NCO frequency control word.
- fcw_valid, output, 1: one-cycle strobe; freq_word was updated this cycle.
- locked, output, 1: carrier lock indicator.

Behaviour:
- Reset (sys_rst=1, asynchronous):
  - integrator = 0, pipeline registers = 0.
  - freq_word = FCW_CENTER, fcw_valid = 0, locked = 0, lock counter = 0, lock FSM = UNLOCKED.
- Arithmetic and widths:
  - e = phase_error sign-extended to ACC_W.
  - p = e <<< KP_SHIFT.
  - i_inc = e <<< KI_SHIFT.
  - All sums are computed in ACC_W+1 bits, then clamped. Intermediates never wrap.
- Pipeline stage 1, on the cycle err_valid=1:
  - Register p.
  - integ <= clamp(integ + i_inc, ±INT_LIMIT).
  - Set v1=1.
- Pipeline stage 2, the cycle after v1=1:
  - corr = clamp(p_reg + integ, ±CORR_LIMIT), where integ is the already-updated value.
  - freq_word <= FCW_CENTER + corr, modulo 2^32. Wrap is intentional because the NCO accumulator wraps.
  - fcw_valid <= 1 for exactly one cycle.
- Latency: err_valid at cycle n gives fcw_valid and the new freq_word at cycle n+2.
- Between strobes: freq_word holds its value and fcw_valid = 0.
- Back-to-back strobes (err_valid on consecutive cycles) are fully supported at one result per cycle.
- loop_clr=1:
  - Next edge: integ <= 0, v1 <= 0, and the pipeline is flushed.
  - freq_word <= FCW_CENTER with fcw_valid <= 1.
  - If loop_clr and err_valid coincide, loop_clr wins and the sample is discarded.
  - loop_clr also resets the lock counter and drives the lock FSM to UNLOCKED.
- Saturation boundaries:
  - phase_error = 16'h8000 (most negative) must be handled without overflow.
  - The integrator sits exactly at ±INT_LIMIT when clamped and does not wind up further.
- Reset asserted mid-pipeline discards any in-flight sample. No fcw_valid follows reset release until a new strobe arrives.

Optional Feature:
- Macro: COSTAS_LOCK_DETECT_EN.
- Defined:
  - Two-state FSM, UNLOCKED and LOCKED, evaluated only on err_valid.
  - In UNLOCKED: the counter increments while |phase_error| < LOCK_THRESH and clears otherwise. On reaching LOCK_CNT it moves to LOCKED, sets locked=1 and clears the counter.
  - In LOCKED: the counter increments while |phase_error| >= LOCK_THRESH and clears otherwise. On reaching LOCK_CNT it moves to UNLOCKED, sets locked=0 and clears the counter.
  - |16'h8000| is treated as 16'h7FFF.
  - The counter saturates and never wraps.
- Not defined: locked is tied to 0 and no counter or FSM logic is generated.

Decomposition:
- Shared package costas_pkg holds:
  - ACC_W and the FCW_CENTER default.
  - A lock_state_t typedef {UNLOCKED, LOCKED}.
  - A sat_clamp function, signed (ACC_W+1) value to ACC_W with a limit argument.
- One natural sub-module: costas_lock_detect (FSM plus counter), instantiated only under COSTAS_LOCK_DETECT_EN.

Test Plan:
- Reset release, no strobes → freq_word = 32'h4000_0000, fcw_valid = 0, locked = 0 for 100 cycles.
- Single strobe with phase_error = 16'd1 at cycle n → fcw_valid at n+2 only, with freq_word = 32'h4000_0000 + 4096 + 16 = 32'h4000_1010.
- 2000 back-to-back strobes with phase_error = 16'h7FFF → integrator pinned at 32'h0100_0000, freq_word = 32'h4000_0000 + 32'h0200_0000 = 32'h4200_0000. Then phase_error = 16'h8000 → integrator recovers monotonically with no wrap glitch.
- Saturated integrator, then loop_clr coinciding with err_valid → next cycle freq_word = 32'h4000_0000, fcw_valid = 1. A following err_valid with phase_error = 0 → freq_word stays 32'h4000_0000.
- COSTAS_LOCK_DETECT_EN defined:
  - 63 strobes with phase_error = 100 → locked = 0.
  - The 64th → locked = 1.
  - One strobe at 3000 followed by 10 in-band strobes → still locked = 1.
  - 64 strobes at 3000 → locked = 0.
- sys_rst asserted for one cycle, one cycle after err_valid → no fcw_valid produced, and all outputs return to their reset values immediately, asynchronously.
